// File: rtl/cla_ctrl_pkg.sv
// Shared types and constants for the multi-precision CLA controller.
package cla_ctrl_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int idx_width(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/cla_adder_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level
// across the groups. P_o/G_o expose block propagate/generate for cascading.
module cla_adder_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o,
  output logic        P_o,
  output logic        G_o
);

  function automatic logic [4:0] lookahead4(input logic [3:0] p, input logic [3:0] g,
                                            input logic c0);
    logic [4:0] c;
    c[0] = c0;
    for (int i = 0; i < 4; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return c;
  endfunction

  logic [15:0] p, g, c;
  logic [3:0]  gp, gg;
  logic [4:0]  gc, gen_all;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      logic [4:0] inner;
      inner  = lookahead4(p[j*4 +: 4], g[j*4 +: 4], 1'b0);
      gp[j]  = &p[j*4 +: 4];
      gg[j]  = inner[4];
    end
  end

  assign gc      = lookahead4(gp, gg, cin_i);
  assign gen_all = lookahead4(gp, gg, 1'b0);

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      logic [4:0] inner;
      inner          = lookahead4(p[j*4 +: 4], g[j*4 +: 4], gc[j]);
      c[j*4 +: 4]    = inner[3:0];
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = gc[4];
  assign P_o    = &gp;
  assign G_o    = gen_all[4];

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/sub that walks one shared 16-bit CLA over WIDTH/16 slices,
// LSB first, chaining the carry through a register; valid/ready on both sides.
module cla_mp_add_seq
  import cla_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("cla_mp_add_seq: WIDTH must be a positive multiple of 16");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic [SLICE_W-1:0] slice_sum;
  logic              slice_cout;
  logic              p_unused, g_unused;

  cla_adder_16bit u_adder (
    .a_i    (a_q[idx_q*SLICE_W +: SLICE_W]),
    .b_i    (b_q[idx_q*SLICE_W +: SLICE_W]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .P_o    (p_unused),
    .G_o    (g_unused)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i)            state_d = RUN;
      RUN:     if (idx_q == LAST_IDX)  state_d = DONE;
      DONE:    if (ready_i)            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b1;
    case (state_q)
      IDLE:    begin ready_o = 1'b1; busy_o = 1'b0; end
      DONE:    valid_o = 1'b1;
      default: ;
    endcase
  end

  // Subtraction is A + ~B + 1, so B is inverted once at capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          a_q     <= a_i;
          b_q     <= sub_i ? ~b_i : b_i;
          carry_q <= sub_i ? 1'b1 : cin_i;
          idx_q   <= '0;
        end
        RUN: begin
          sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = carry_q;
  assign ovf_o  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Directed bench for cla_mp_add_seq: 64-bit vector table plus backpressure,
// mid-run reset and a 16-bit build.
module tb_cla_mp_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        vin, rdy_o, rdy_i, cin, sub, vout, cout, ovf, busy;
  logic [63:0] a, b, sum;

  logic        vin16, rdy_o16, rdy_i16, cin16, sub16, vout16, cout16, ovf16, busy16;
  logic [15:0] a16, b16, sum16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_mp_add_seq #(.WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(vin), .ready_o(rdy_o), .a_i(a), .b_i(b),
    .cin_i(cin), .sub_i(sub), .valid_o(vout), .ready_i(rdy_i), .sum_o(sum),
    .cout_o(cout), .ovf_o(ovf), .busy_o(busy)
  );

  cla_mp_add_seq #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin16), .ready_o(rdy_o16), .a_i(a16), .b_i(b16),
    .cin_i(cin16), .sub_i(sub16), .valid_o(vout16), .ready_i(rdy_i16), .sum_o(sum16),
    .cout_o(cout16), .ovf_o(ovf16), .busy_o(busy16)
  );

  typedef struct {
    string       name;
    logic [63:0] a, b;
    logic        cin, sub;
    logic [63:0] esum;
    logic        ecout, eovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int cyc;
    @(negedge clk);
    chk({v.name, " ready"}, rdy_o, 1);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; vin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    chk({v.name, " busy"}, {busy, rdy_o}, 2'b10);
    cyc = 0;
    while (!vout && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({v.name, " latency"}, cyc, 4);
    chk({v.name, " sum"}, sum, v.esum);
    chk({v.name, " cout/ovf"}, {cout, ovf}, {v.ecout, v.eovf});
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    chk({v.name, " back idle"}, {vout, rdy_o, busy}, 3'b010);
    chk({v.name, " sum kept"}, sum, v.esum);
  endtask

  vec_t vecs[8];

  initial begin
    int cyc;
    vecs[0] = '{"all1+1",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{"0-1",      64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{"5-3",      64'h5, 64'h3, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[3] = '{"maxpos+1", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{"0+0+cin",  64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};
    vecs[5] = '{"sub cin ignored", 64'd10, 64'd10, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[6] = '{"mixed add", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[7] = '{"minneg-1", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    rst = 1'b1; vin = 1'b0; rdy_i = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    vin16 = 1'b0; rdy_i16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", {rdy_o, vout, busy}, 3'b100);
    chk("reset out", {sum, cout, ovf}, 66'h0);
    chk("reset16 ctl", {rdy_o16, vout16, busy16}, 3'b100);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure with valid_i held high and operands changed after accept.
    @(negedge clk);
    a = 64'h1111; b = 64'h2222; vin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 64'd100; b = 64'd23;
    cyc = 0;
    while (!vout && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp latency", cyc, 4);
    for (int k = 0; k < 5; k++) begin
      chk("bp hold sum", sum, 64'h3333);
      chk("bp hold ctl", {vout, rdy_o, cout, ovf}, 4'b1000);
      @(negedge clk);
    end
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    chk("bp idle", {vout, rdy_o, busy}, 3'b010);
    @(negedge clk);
    vin = 1'b0;
    chk("bp second accepted", {busy, rdy_o}, 2'b10);
    cyc = 0;
    while (!vout && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp2 latency", cyc, 4);
    chk("bp2 sum", sum, 64'd123);
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;

    // Reset while idx==2 in RUN.
    a = 64'h5555_5555_5555_5555; b = 64'h1111_1111_1111_1111; vin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort ctl", {vout, busy, rdy_o}, 3'b001);
    chk("abort out", {sum, cout, ovf}, 66'h0);
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (vout) cyc++;
    end
    chk("abort no result", cyc, 0);
    run_op('{"3+4 after abort", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0});

    // 16-bit build.
    @(negedge clk);
    a16 = 16'h8000; b16 = 16'h8000; vin16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin16 = 1'b0;
    cyc = 0;
    while (!vout16 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("w16 latency", cyc, 1);
    chk("w16 result", {sum16, cout16, ovf16}, {16'h0, 1'b1, 1'b1});
    rdy_i16 = 1'b1;
    @(negedge clk);
    rdy_i16 = 1'b0;
    chk("w16 idle", {vout16, rdy_o16, busy16}, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
